// File: rtl/sprite_scanline_renderer.sv
// Single-sprite scanline renderer: fetches one ROM row during horizontal blank
// for the next line, then shifts it out as a registered 1-bit pixel stream.
module sprite_scanline_renderer #(
  parameter int H_DISPLAY = 256,
  parameter int V_DISPLAY = 256,
  parameter int V_TOTAL   = 278,
  parameter int WIDTH     = 8,
  parameter int ROW_BITS  = 4,
  parameter int FETCH_H   = H_DISPLAY + WIDTH
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [8:0]          hpos,
  input  logic [8:0]          vpos,
  input  logic                sprite_en,
  input  logic [8:0]          sprite_x,
  input  logic [8:0]          sprite_y,
  input  logic                sprite_hflip,
  output logic [ROW_BITS-1:0] rom_addr,
  input  logic [WIDTH-1:0]    rom_data,
  output logic                gfx,
  output logic                active
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [8:0]    H_DISP9   = 9'(H_DISPLAY);
  localparam logic [8:0]    H_LAST9   = 9'(H_DISPLAY - 1);
  localparam logic [8:0]    V_DISP9   = 9'(V_DISPLAY);
  localparam logic [8:0]    V_LAST9   = 9'(V_TOTAL - 1);
  localparam logic [8:0]    FETCH9    = 9'(FETCH_H);
  localparam logic [8:0]    HEIGHT9   = 9'(2 ** ROW_BITS);
  localparam logic [CW-1:0] CNT_DONE  = CW'(WIDTH);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, WAIT_X, DRAW} state_t;

  state_t              state_q, state_d;
  logic [ROW_BITS-1:0] romAddr_q, romAddr_d;
  logic [8:0]          target_q, target_d;
  logic                en_q, en_d;
  logic [8:0]          x_q, x_d;
  logic [8:0]          y_q, y_d;
  logic                flip_q, flip_d;
  logic [WIDTH-1:0]    shreg_q, shreg_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                gfx_q, gfx_d;

  logic [8:0]          nextLine;
  logic [8:0]          row;
  logic                hit;
  logic [WIDTH-1:0]    romRev;

  // Row lookahead for the line after the current one; row wraps modulo 512.
  always_comb begin
    nextLine = (vpos == V_LAST9) ? 9'd0 : vpos + 9'd1;
    row      = nextLine - y_q;
    hit      = en_q && (row < HEIGHT9) && (nextLine < V_DISP9);
    romRev   = '0;
    for (int i = 0; i < WIDTH; i++) romRev[i] = rom_data[WIDTH-1-i];
  end

  always_comb begin
    state_d   = state_q;
    romAddr_d = romAddr_q;
    target_d  = target_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    gfx_d     = 1'b0;
    en_d      = en_q;
    x_d       = x_q;
    y_d       = y_q;
    flip_d    = flip_q;

    if (hpos == 9'd0 && vpos == V_DISP9) begin
      en_d   = sprite_en;
      x_d    = sprite_x;
      y_d    = sprite_y;
      flip_d = sprite_hflip;
    end

    case (state_q)
      IDLE: begin
        if (hpos == FETCH9 && hit) begin
          romAddr_d = row[ROW_BITS-1:0];
          target_d  = nextLine;
          state_d   = FETCH;
        end
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        shreg_d = flip_q ? romRev : rom_data;
        state_d = WAIT_X;
      end
      WAIT_X: begin
        if (vpos == target_q) begin
          if (hpos == x_q && x_q < H_DISP9) begin
            gfx_d   = shreg_q[WIDTH-1];
            shreg_d = shreg_q << 1;
            cnt_d   = CW'(1);
            state_d = DRAW;
          end else if (hpos == H_LAST9) begin
            state_d = IDLE;
          end
        end
      end
      DRAW: begin
        // Columns past the visible area are shifted out but blanked.
        if (cnt_q == CNT_DONE) begin
          state_d = IDLE;
        end else begin
          gfx_d   = shreg_q[WIDTH-1] && (hpos < H_DISP9);
          shreg_d = shreg_q << 1;
          cnt_d   = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      romAddr_q <= '0;
      target_q  <= '0;
      en_q      <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      flip_q    <= 1'b0;
      shreg_q   <= '0;
      cnt_q     <= '0;
      gfx_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      romAddr_q <= romAddr_d;
      target_q  <= target_d;
      en_q      <= en_d;
      x_q       <= x_d;
      y_q       <= y_d;
      flip_q    <= flip_d;
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      gfx_q     <= gfx_d;
    end
  end

  assign rom_addr = romAddr_q;
  assign gfx      = gfx_q;
  assign active   = (state_q != IDLE);

endmodule

// File: tb/tb_sprite_scanline_renderer.sv
// Directed bench for sprite_scanline_renderer: beam counters and a registered
// sprite ROM are driven from the bench; per-column results are captured per line.
module tb_sprite_scanline_renderer;

  localparam int H_TOTAL = 270;

  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] hpos, vpos;
  logic       sprite_en;
  logic [8:0] sprite_x, sprite_y;
  logic       sprite_hflip;
  logic [3:0] rom_addr;
  logic [7:0] rom_data;
  logic       gfx, active;

  int vectors = 0;
  int miscompares = 0;
  int romMode = 0;

  // Captured outputs after the edge that sampled hpos==h (gfx = pixel of column h).
  logic       gfxS  [0:H_TOTAL-1];
  logic       actS  [0:H_TOTAL-1];
  logic [3:0] addrS [0:H_TOTAL-1];
  int onesCnt, actCnt, addrNz;

  sprite_scanline_renderer dut (
    .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos),
    .sprite_en(sprite_en), .sprite_x(sprite_x), .sprite_y(sprite_y),
    .sprite_hflip(sprite_hflip), .rom_addr(rom_addr), .rom_data(rom_data),
    .gfx(gfx), .active(active)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] romFn(input logic [3:0] a);
    case (romMode)
      0:       romFn = 8'hA5;
      1:       romFn = 8'hF0;
      2:       romFn = 8'hFF;
      default: romFn = {a, 4'b1001};
    endcase
  endfunction

  function automatic logic [7:0] lineByte(input int x0);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[7-i] = gfxS[x0+i];
    return r;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; the ROM returns data one cycle after the address it saw.
  task automatic tick();
    logic [3:0] a;
    a = rom_addr;
    @(posedge clk);
    #1;
    rom_data = romFn(a);
  endtask

  task automatic clearStats();
    onesCnt = 0; actCnt = 0; addrNz = 0;
    for (int h = 0; h < H_TOTAL; h++) begin
      gfxS[h] = 1'b0; actS[h] = 1'b0; addrS[h] = '0;
    end
  endtask

  task automatic runSpan(input int v, input int h0, input int h1);
    for (int h = h0; h <= h1; h++) begin
      hpos = 9'(h);
      vpos = 9'(v);
      tick();
      gfxS[h] = gfx; actS[h] = active; addrS[h] = rom_addr;
      if (gfx === 1'b1) onesCnt++;
      if (active === 1'b1) actCnt++;
      if (rom_addr !== 4'd0) addrNz++;
    end
  endtask

  task automatic runLine(input int v);
    clearStats();
    runSpan(v, 0, H_TOTAL - 1);
  endtask

  task automatic doReset();
    hpos = 9'd0; vpos = 9'd0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic latchFrame();
    hpos = 9'd0; vpos = 9'd256;
    tick();
  endtask

  initial begin
    reset = 1'b1; hpos = '0; vpos = '0; rom_data = '0;
    sprite_en = 1'b1; sprite_x = '0; sprite_y = '0; sprite_hflip = 1'b0;

    // Reset, then run without any latch: nothing may happen.
    repeat (5) tick();
    check("reset gfx", 16'(gfx), 16'd0);
    check("reset active", 16'(active), 16'd0);
    check("reset rom_addr", 16'(rom_addr), 16'd0);
    reset = 1'b0;
    clearStats();
    runSpan(277, 0, H_TOTAL - 1);
    runSpan(0, 0, H_TOTAL - 1);
    runSpan(1, 0, H_TOTAL - 1);
    check("unlatched gfx count", 16'(onesCnt), 16'd0);
    check("unlatched active count", 16'(actCnt), 16'd0);
    check("unlatched rom_addr nonzero", 16'(addrNz), 16'd0);

    // Basic draw x=100 y=50, ROM A5.
    romMode = 0; sprite_x = 9'd100; sprite_y = 9'd50;
    latchFrame();
    runLine(48);
    check("basic line48 active", 16'(actCnt), 16'd0);
    runLine(49);
    check("basic line49 gfx", 16'(onesCnt), 16'd0);
    check("basic line49 fetch", 16'(actS[264]), 16'd1);
    check("basic line49 rom_addr", 16'(addrS[264]), 16'd0);
    runLine(50);
    check("basic line50 pixels", 16'(lineByte(100)), 16'h00A5);
    check("basic line50 ones", 16'(onesCnt), 16'd4);
    check("basic line50 rom_addr", 16'(addrS[264]), 16'd1);
    for (int v = 51; v <= 65; v++) begin
      runLine(v);
      check($sformatf("basic line%0d pixels", v), 16'(lineByte(100)), 16'h00A5);
      if (v == 64) check("basic line64 rom_addr", 16'(addrS[264]), 16'd15);
      if (v == 65) check("basic line65 no fetch", 16'(actS[264]), 16'd0);
    end
    runLine(66);
    check("basic line66 gfx", 16'(onesCnt), 16'd0);
    check("basic line66 active", 16'(actCnt), 16'd0);

    // Horizontal flip.
    doReset();
    romMode = 1; sprite_hflip = 1'b1;
    latchFrame();
    runLine(49);
    runLine(50);
    check("flip pixels", 16'(lineByte(100)), 16'h000F);

    // Right-edge clipping, x=252.
    doReset();
    romMode = 2; sprite_hflip = 1'b0; sprite_x = 9'd252;
    latchFrame();
    runLine(49);
    runLine(50);
    check("clip252 visible", 16'({gfxS[252], gfxS[253], gfxS[254], gfxS[255]}), 16'hF);
    check("clip252 ones", 16'(onesCnt), 16'd4);
    check("clip252 draw at 259", 16'(actS[259]), 16'd1);
    check("clip252 idle at 260", 16'(actS[260]), 16'd0);

    // Fully off-screen, x=300.
    doReset();
    sprite_x = 9'd300;
    latchFrame();
    runLine(49);
    runLine(50);
    check("x300 ones", 16'(onesCnt), 16'd0);
    check("x300 waiting at 254", 16'(actS[254]), 16'd1);
    check("x300 idle at 255", 16'(actS[255]), 16'd0);

    // Top edge, y=0: fetched on the last line of the frame.
    doReset();
    romMode = 3; sprite_x = 9'd100; sprite_y = 9'd0;
    latchFrame();
    runLine(277);
    check("y0 idle before fetch", 16'(actS[263]), 16'd0);
    check("y0 fetch", 16'(actS[264]), 16'd1);
    check("y0 rom_addr", 16'(addrS[264]), 16'd0);
    runLine(0);
    check("y0 line0 pixels", 16'(lineByte(100)), 16'h0009);

    // Bottom edge, y=250.
    doReset();
    sprite_y = 9'd250;
    latchFrame();
    runLine(249);
    check("y250 fetch", 16'(actS[264]), 16'd1);
    for (int v = 250; v <= 255; v++) begin
      runLine(v);
      check($sformatf("y250 line%0d pixels", v), 16'(lineByte(100)), 16'({4'(v - 250), 4'b1001}));
    end
    check("y250 no fetch at 255", 16'(actS[264]), 16'd0);
    check("y250 idle end 255", 16'(actS[269]), 16'd0);

    // Wrapped top, y=510: rows 2..15 on lines 0..13.
    doReset();
    sprite_y = 9'd510;
    latchFrame();
    runLine(277);
    check("y510 rom_addr", 16'(addrS[264]), 16'd2);
    for (int v = 0; v <= 13; v++) begin
      runLine(v);
      check($sformatf("y510 line%0d pixels", v), 16'(lineByte(100)), 16'({4'(v + 2), 4'b1001}));
    end
    check("y510 no fetch at 13", 16'(actS[264]), 16'd0);
    runLine(14);
    check("y510 line14 gfx", 16'(onesCnt), 16'd0);

    // Mid-frame sprite_x change, then reset during DRAW.
    doReset();
    romMode = 0; sprite_x = 9'd100; sprite_y = 9'd100;
    latchFrame();
    runLine(99);
    sprite_x = 9'd20;
    runLine(100);
    check("latch line100 pixels", 16'(lineByte(100)), 16'h00A5);
    runLine(101);
    check("latch line101 pixels", 16'(lineByte(100)), 16'h00A5);
    check("latch line101 ones", 16'(onesCnt), 16'd4);
    clearStats();
    runSpan(102, 0, 102);
    check("pre-reset gfx", 16'(gfx), 16'd1);
    check("pre-reset active", 16'(active), 16'd1);
    reset = 1'b1; hpos = 9'd103; vpos = 9'd102;
    tick();
    check("midreset gfx", 16'(gfx), 16'd0);
    check("midreset active", 16'(active), 16'd0);
    check("midreset rom_addr", 16'(rom_addr), 16'd0);
    reset = 1'b0;
    clearStats();
    runSpan(102, 104, H_TOTAL - 1);
    runSpan(103, 0, H_TOTAL - 1);
    check("post-reset ones", 16'(onesCnt), 16'd0);
    check("post-reset active", 16'(actCnt), 16'd0);
    latchFrame();
    runLine(99);
    runLine(100);
    check("relatched pixels", 16'(lineByte(20)), 16'h00A5);
    check("relatched ones", 16'(onesCnt), 16'd4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
